// File: rtl/aes_pkg.sv
// Shared AES column arithmetic: GF(2^8) helpers, state/column types and the mixing mode.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    typedef enum logic {
        MIX_FWD = 1'b0,
        MIX_INV = 1'b1
    } mix_mode_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // Shift-and-add multiply; with a constant k the unused branches fold away.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = x;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column (row 0 in the top byte).
module mix_column_unit
    import aes_pkg::*;
(
    input  aes_col_t col_i,
    input  logic     inverse_i,
    output aes_col_t col_o
);

    // Row 0 coefficients; row r is the same list rotated right by r.
    localparam logic [7:0] FWD_K [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [7:0] INV_K [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    logic [7:0] a [4];
    logic [7:0] f [4];
    logic [7:0] v [4];

    always_comb begin
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            a[r] = col_i[24-8*r +: 8];
        end
        for (int r = 0; r < 4; r++) begin
            f[r] = '0;
            v[r] = '0;
            for (int i = 0; i < 4; i++) begin
                f[r] = f[r] ^ gf_mul(a[i], FWD_K[(i - r + 4) % 4]);
                v[r] = v[r] ^ gf_mul(a[i], INV_K[(i - r + 4) % 4]);
            end
            col_o[24-8*r +: 8] = inverse_i ? v[r] : f[r];
        end
    end

endmodule

// File: rtl/mix_columns_engine.sv
// Folded valid/ready AES MixColumns engine: COLS_PER_CYCLE columns per clock, result held until taken.
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       inverse,
    input  aes_state_t state_in,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t state_out
);

    localparam int C = COLS_PER_CYCLE;
    localparam logic [1:0] CNT_LAST = 2'(4 / C - 1);

    if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t       state_q;
    logic [1:0] cnt_q;
    aes_state_t work_q;
    aes_state_t res_q;
    mix_mode_t  mode_q;
    logic       out_valid_q;
    logic       alive_q;
    logic       accept;

    logic [C-1:0][1:0] col_idx;
    aes_col_t [C-1:0]  col_in;
    aes_col_t [C-1:0]  col_out;

    for (genvar j = 0; j < C; j++) begin : g_col
        assign col_idx[j] = 2'(int'(cnt_q) * C + j);
        assign col_in[j]  = work_q[{col_idx[j], 5'd0} +: 32];

        mix_column_unit u_mcu (
            .col_i     (col_in[j]),
            .inverse_i (mode_q == MIX_INV),
            .col_o     (col_out[j])
        );
    end

    // alive_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = alive_q && ((state_q == IDLE) || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign state_out = res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            res_q       <= '0;
            mode_q      <= MIX_FWD;
            out_valid_q <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            case (state_q)
                RUN: begin
                    for (int j = 0; j < C; j++) begin
                        res_q[{col_idx[j], 5'd0} +: 32] <= col_out[j];
                    end
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Accept overrides the IDLE/DONE next state, giving same-cycle hand-over.
            if (accept) begin
                work_q  <= state_in;
                mode_q  <= mix_mode_t'(inverse);
                cnt_q   <= '0;
                state_q <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench: three engines (1, 2, 4 columns per cycle) driven in lockstep and checked against known vectors.
module tb_mix_columns_engine;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         inverse;
    logic [127:0] state_in;
    logic         out_ready;
    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [127:0] so [3];

    int tests;
    int fails;

    localparam logic [127:0] VA = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] VB = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] VF = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101;
    localparam logic [127:0] VD = 128'hd4d4d4d5_01010101_c6c6c6c6_d4d4d4d5;
    localparam logic [127:0] VE = 128'hd5d5d7d6_01010101_c6c6c6c6_d5d5d7d6;

    mix_columns_engine #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .inverse(inverse),
        .state_in(state_in), .out_valid(ov[0]), .out_ready(out_ready), .state_out(so[0]));
    mix_columns_engine #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .inverse(inverse),
        .state_in(state_in), .out_valid(ov[1]), .out_ready(out_ready), .state_out(so[1]));
    mix_columns_engine #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .inverse(inverse),
        .state_in(state_in), .out_valid(ov[2]), .out_ready(out_ready), .state_out(so[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; all three engines must be ready.
    task automatic accept(input logic [127:0] s, input logic inv);
        state_in = s;
        inverse  = inv;
        in_valid = 1'b1;
        #1;
        chk("in_ready_before_accept", 128'(ir), 128'(3'b111));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scrambles state_in/inverse every cycle so a result can only come from the accepted values.
    task automatic collect(input logic [127:0] exp, input string tag);
        int           lat [3];
        logic [127:0] got [3];
        for (int d = 0; d < 3; d++) begin
            lat[d] = 0;
            got[d] = '0;
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && lat[d] == 0) begin
                    lat[d] = k;
                    got[d] = so[d];
                end
            end
            state_in = {$urandom, $urandom, $urandom, $urandom};
            inverse  = ~inverse;
        end
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_latency"}, 128'(lat[d]), 128'((d == 0) ? 4 : (d == 1) ? 2 : 1));
            chk({tag, "_data"}, got[d], exp);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        inverse   = 1'b0;
        state_in  = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(ir), 128'(3'b000));
        chk("rst_out_valid", 128'(ov), 128'(3'b000));
        chk("rst_state_out", so[0], 128'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("alive_gate_low", 128'(ir[0]), 128'(1'b0));
        @(posedge clk);
        #1;
        chk("alive_gate_high", 128'(ir[0]), 128'(1'b1));

        accept(VA, 1'b0);
        collect(VB, "fwd_A");
        accept(VB, 1'b1);
        collect(VA, "inv_B");
        accept(VF, 1'b0);
        collect(VF, "fix_fwd");
        accept(VF, 1'b1);
        collect(VF, "fix_inv");
        accept(VD, 1'b0);
        collect(VE, "d4_fwd");

        // Back-pressure: result of VE->VD held while downstream stalls, then same-cycle hand-over.
        out_ready = 1'b0;
        accept(VE, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b1;
        state_in = VB;
        inverse  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("stall_state_out", so[0], VD);
            chk("stall_in_ready", 128'(ir), 128'(3'b000));
            chk("stall_out_valid", 128'(ov), 128'(3'b111));
        end
        chk("stall_c4_state_out", so[2], VD);
        out_ready = 1'b0;
        state_in  = VA;
        inverse   = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("handover_in_ready", 128'(ir), 128'(3'b111));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("handover_out_valid", 128'(ov), 128'(3'b000));
        collect(VB, "after_handover");

        // Reset during the second RUN cycle of the 1-column engine.
        accept(VA, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_out_valid", 128'(ov), 128'(3'b000));
        chk("midrun_state_out", so[0], 128'h0);
        chk("midrun_c4_state_out", so[2], 128'h0);
        chk("midrun_in_ready", 128'(ir), 128'(3'b000));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready_low", 128'(ir), 128'(3'b000));
        @(posedge clk);
        #1;
        chk("release_in_ready_high", 128'(ir), 128'(3'b111));
        accept(VB, 1'b1);
        collect(VA, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mix_columns_engine.md
# mix_columns_engine

Folded, handshaked AES MixColumns / InvMixColumns engine for the cipher datapath. It accepts one 128-bit state per transaction and a per-transaction direction bit. It processes `COLS_PER_CYCLE` columns per clock and holds the result until the downstream stage takes it. It supersedes the purely combinational inverse-only column mixer: it covers both directions, has a width/latency trade-off, and has valid/ready flow control on both sides.

## Interface
- `COLS_PER_CYCLE`, default 1: number of 32-bit columns mixed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: upstream has a state on `state_in`.
- `in_ready` output 1: engine can accept a state this cycle.
- `inverse` input 1: 0 selects MixColumns, 1 selects InvMixColumns. Sampled together with `state_in` on accept.
- `state_in` input 128: input state. Column i is `[i*32+:32]`. Row 0 byte is `[i*32+24+:8]` and row 3 byte is `[i*32+:8]`.
- `out_valid` output 1: `state_out` holds a finished result.
- `out_ready` input 1: downstream takes the result this cycle.
- `state_out` output 128: mixed state, same column/row layout as `state_in`.

## Operation
- Column arithmetic is in GF(2^8) with reduction polynomial 0x11b.
  - xtime(x) = (x<<1) ^ (x[7] ? 0x1b : 0), truncated to 8 bits.
  - Addition is XOR.
- Forward mixing: each output column is the circulant matrix with rows {02,03,01,01}, {01,02,03,01}, {01,01,02,03}, {03,01,01,02} applied to input column (a0..a3), where a0 is row 0.
- Inverse mixing: same structure with rows {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid`, latch `state_in` into the work register, latch `inverse` into the mode register, clear the column counter, and go to RUN.
  - RUN: each cycle, mix columns `cnt*C .. cnt*C+C-1` (C = `COLS_PER_CYCLE`) from the work register into the result register, then increment `cnt`. When `cnt` = 4/C−1, go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE, or go directly to RUN if a new state is accepted in the same cycle.
- `in_ready` = (IDLE) or (DONE and `out_ready`). This is a combinational path from `out_ready` to `in_ready`, and it is allowed.
- `in_ready` is held 0 while `rst_n` is low and for the first edge after deassertion (gated by a registered "alive" flag).
- Changes to `state_in` or `inverse` after accept have no effect on the transaction in flight.
- In DONE, `state_out` is stable until the handshake completes.
- `in_valid` without `in_ready` leaves the engine unchanged. Upstream must hold its data (standard valid/ready rules).

## Timing
- Reset values: FSM IDLE, `cnt`=0, `out_valid`=0, `state_out`=128'h0, mode register 0, `in_ready`=0 during reset.
- Latency: accept on edge E, then RUN occupies edges E+1 .. E+4/C. `out_valid` rises after edge E+4/C, giving 4, 2 or 1 cycles for C = 1, 2, 4.
- Throughput with `out_ready` held high: one state every 4/C+1 cycles (back-to-back accept in DONE).
- `out_ready` low in DONE: the engine stalls indefinitely, `in_ready`=0, and the result is retained.
- Reset asserted mid-RUN or mid-DONE: the transaction is aborted immediately and asynchronously. All outputs return to reset values and no partial result is ever presented.
- `state_out` is driven directly from the result register; there is no combinational path from `state_in` to `state_out`.

## Structure
- Shared package `aes_pkg`:
  - `AES_POLY` = 8'h1b.
  - Functions `gf_xtime` and `gf_mul` (multiply by an 8-bit constant using an xtime chain).
  - Mode enum `MIX_FWD`/`MIX_INV`.
  - Typedefs `aes_state_t` (128 bits) and `aes_col_t` (32 bits).
- Sub-module `mix_column_unit`: combinational, one `aes_col_t` in, one out, plus an `inverse` select. It is instantiated `COLS_PER_CYCLE` times by a generate loop.
- The FSM, counter, and work/result registers live in `mix_columns_engine`.

## Test plan
- Forward with C=1: accept 128'hdb135345_f20a225c_01010101_2d26314c with `inverse`=0. Require `state_out`=128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8 and `out_valid` exactly 4 cycles after accept.
- Inverse round-trip for C=1, 2 and 4: feed 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8 with `inverse`=1. Require 128'hdb135345_f20a225c_01010101_2d26314c, with latency 4, 2 and 1 cycles respectively.
- Fixed points: 128'hc6c6c6c6_01010101_c6c6c6c6_01010101 maps to itself in both modes. 128'hd4d4d4d5_… gives a column of d5d5d7d6 in forward mode.
- Back-pressure: hold `out_ready`=0 for 10 cycles in DONE. Require `state_out` stable, `in_ready`=0, and no accept. When `out_ready` rises together with `in_valid`, require a same-cycle hand-over and the next result 4/C cycles later.
- Mode isolation: toggle `inverse` and `state_in` every cycle during RUN. Require the result to match the values sampled at accept.
- Reset mid-RUN: drop `rst_n` on the second RUN cycle. Require `out_valid`=0 and `state_out`=0 immediately, `in_ready`=0 for the first edge after release and 1 thereafter, and a subsequent transaction correct.
